input_word_sequencer: RTL and testbench
=======================================

// Module: input_word_sequencer
// PURPOSE
// - Holds the 1024-bit candidate input block and steps the 4-bit word index 0..15, one word per accepted beat.
// - Drives the register and word index of the downstream x0 word selector, which feeds the Skein UBI/Threefish stage.
// - Optional auto-increment of the low nonce field lets brute-force search run back-to-back blocks without reloading.
// PARAMETERS
// - WORDS    16  words per block; word index width = $clog2(WORDS) = 4
// - WORD_W   64  bits per word; block width = WORDS*WORD_W = 1024
// - NONCE_W  64  low bits of the block incremented in auto mode (1..WORDS*WORD_W)
// PORTS
// - clk_i             in   1     single clock, rising edge
// - rst_n_i           in   1     asynchronous, active-low reset
// - load_valid_i      in   1     new block offered
// - load_ready_o      out  1     sequencer can accept a block (IDLE only)
// - load_data_i       in   1024  block to load
// - auto_inc_i        in   1     at end of block: increment nonce and restart
// - stop_i            in   1     finish current block, then return to IDLE
// - input_register_o  out  1024  held block, to x0 selector
// - word_o            out  4     current word index, to x0 selector
// - word_valid_o      out  1     word_o/input_register_o present a valid word
// - word_ready_i      in   1     downstream consumes the word this cycle
// - last_o            out  1     word_valid_o && word_o==15
// - block_count_o     out  32    completed blocks since reset, wraps mod 2^32
// - busy_o            out  1     state != IDLE
// BEHAVIOUR
// - Reset (async assert, sync-release design): state=IDLE; input_register_o=0, word_o=0, word_valid_o=0,
//   last_o=0, block_count_o=0, busy_o=0, load_ready_o=1; internal stop latch cleared.
// - FSM states: IDLE, STREAM.
// - IDLE: load_ready_o=1. On load_valid_i: register<=load_data_i, word<=0, ->STREAM.
//   word_valid_o rises the cycle after acceptance (load-to-first-word latency 1).
// - STREAM: load_ready_o=0 (load_valid_i ignored, nothing latched). word_valid_o=1 continuously.
//   Beat = word_valid_o && word_ready_i. On beat with word<15: word<=word+1.
//   Without beat: word_o and input_register_o hold (stall of any length allowed).
// - End of block (beat with word==15): block_count+=1 (wrap), word<=0, then:
//   - auto_inc_i==1 and no stop pending: register[NONCE_W-1:0] <= +1 mod 2^NONCE_W (upper bits unchanged),
//     stay STREAM; next cycle presents word 0 of the new block (zero bubble).
//   - otherwise: ->IDLE, word_valid_o=0 next cycle; register keeps last block value.
// - stop_i: sampled any cycle in STREAM into a stop latch; latch cleared on entry to IDLE.
//   stop_i in the same cycle as the last beat counts as pending (block ends, ->IDLE).
//   stop_i in IDLE has no effect.
// - auto_inc_i is sampled only on the last beat.
// - Nonce wrap: all-ones low field +1 -> all-zeros, no carry into bit NONCE_W.
// - input_register_o changes only on load acceptance or on the end-of-block increment, never mid-block.
// - Reset asserted mid-block: immediate return to reset values; partial block is discarded and not counted.
// STRUCTURE
// - Shared package: WORDS, WORD_W, BLOCK_W, WORD_IDX_W, and the state enum {IDLE, STREAM}.
// - Single flat module: state register, word counter, stop latch, block counter, and the register
//   with load and nonce-increment mux.
// - No sub-module; the x0 word selector is a separate downstream instance wired at the parent level.
// TESTING
// - Load 1024'h..0F0E..00 (word k = k), word_ready_i=1, auto_inc_i=0 -> word_o 0..15 on 16 consecutive
//   cycles, last_o only on 15, then IDLE; block_count_o=1.
// - Same load, word_ready_i low for 3 cycles at word 5 -> word_o holds at 5, register stable; total 19 valid cycles.
// - auto_inc_i=1, low nonce=64'hFFFF_FFFF_FFFF_FFFE, 3 blocks -> nonce FE, FF, 00 with upper bits unchanged;
//   no gap between word 15 and word 0; block_count_o=3.
// - auto_inc_i=1, stop_i pulsed at word 7 of block 2 -> block 2 completes, ->IDLE, block_count_o=2,
//   load_ready_o=1.
// - load_valid_i held high during STREAM with a different value -> ignored; register and word sequence unaffected.
// - rst_n_i low at word 9 -> word_valid_o=0, word_o=0, block_count_o=0 immediately; a fresh load restarts at word 0.

Source files
------------

// File: rtl/input_word_sequencer_pkg.sv
// Shared sizing constants and FSM state encoding for the input word sequencer.
package input_word_sequencer_pkg;
  localparam int WORDS      = 16;
  localparam int WORD_W     = 64;
  localparam int BLOCK_W    = WORDS * WORD_W;
  localparam int WORD_IDX_W = $clog2(WORDS);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } seq_state_e;
endpackage

// File: rtl/input_word_sequencer.sv
// Holds a candidate input block and steps its word index for the downstream x0 selector,
// with optional low-nonce auto-increment for back-to-back brute-force blocks.
module input_word_sequencer
  import input_word_sequencer_pkg::*;
#(
  parameter int NONCE_W = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [BLOCK_W-1:0]    load_data_i,
  input  logic                  auto_inc_i,
  input  logic                  stop_i,
  output logic [BLOCK_W-1:0]    input_register_o,
  output logic [WORD_IDX_W-1:0] word_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  last_o,
  output logic [31:0]           block_count_o,
  output logic                  busy_o
);

  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS - 1);

  seq_state_e            state_reg, state_next;
  logic [WORD_IDX_W-1:0] word_reg, word_next;
  logic [BLOCK_W-1:0]    data_reg, data_next;
  logic [BLOCK_W-1:0]    data_incr;
  logic [NONCE_W-1:0]    nonce_inc;
  logic                  stop_reg, stop_next;
  logic [31:0]           count_reg, count_next;
  logic                  beat;
  logic                  stop_pending;

  // Only the low nonce field advances; it wraps without carrying into the upper bits.
  assign nonce_inc = data_reg[NONCE_W-1:0] + NONCE_W'(1);

  generate
    if (NONCE_W < BLOCK_W) begin : g_partial_nonce
      assign data_incr = {data_reg[BLOCK_W-1:NONCE_W], nonce_inc};
    end else begin : g_full_nonce
      assign data_incr = nonce_inc;
    end
  endgenerate

  assign beat         = (state_reg == STREAM) && word_ready_i;
  assign stop_pending = stop_reg || stop_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      data_reg  <= '0;
      stop_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      data_reg  <= data_next;
      stop_reg  <= stop_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    data_next  = data_reg;
    stop_next  = stop_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        stop_next = 1'b0;
        if (load_valid_i) begin
          data_next  = load_data_i;
          word_next  = '0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        stop_next = stop_pending;
        if (beat) begin
          if (word_reg == LAST_WORD) begin
            count_next = count_reg + 32'd1;
            word_next  = '0;
            if (auto_inc_i && !stop_pending) begin
              data_next = data_incr;
            end else begin
              state_next = IDLE;
              stop_next  = 1'b0;
            end
          end else begin
            word_next = word_reg + WORD_IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_ready_o     = (state_reg == IDLE);
  assign busy_o           = (state_reg != IDLE);
  assign word_valid_o     = (state_reg == STREAM);
  assign last_o           = word_valid_o && (word_reg == LAST_WORD);
  assign word_o           = word_reg;
  assign input_register_o = data_reg;
  assign block_count_o    = count_reg;

endmodule

// File: tb/tb_input_word_sequencer.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_input_word_sequencer;
  import input_word_sequencer_pkg::*;

  typedef struct {
    logic [WORD_IDX_W-1:0] word;
    logic [BLOCK_W-1:0]    blk;
    logic                  last;
  } exp_t;

  logic                  clk_i = 1'b0;
  logic                  rst_n_i = 1'b0;
  logic                  load_valid_i = 1'b0;
  logic                  load_ready_o;
  logic [BLOCK_W-1:0]    load_data_i = '0;
  logic                  auto_inc_i = 1'b0;
  logic                  stop_i = 1'b0;
  logic [BLOCK_W-1:0]    input_register_o;
  logic [WORD_IDX_W-1:0] word_o;
  logic                  word_valid_o;
  logic                  word_ready_i = 1'b1;
  logic                  last_o;
  logic [31:0]           block_count_o;
  logic                  busy_o;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;
  int last_cycles = 0;
  logic [BLOCK_W-1:0] blk_a, blk_b, blk_c, blk_d;

  input_word_sequencer #(.NONCE_W(64)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .load_valid_i(load_valid_i), .load_ready_o(load_ready_o), .load_data_i(load_data_i),
    .auto_inc_i(auto_inc_i), .stop_i(stop_i),
    .input_register_o(input_register_o), .word_o(word_o), .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i), .last_o(last_o), .block_count_o(block_count_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_blk(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      for (int k = 0; k < WORDS; k++) begin
        if (act[k*WORD_W +: WORD_W] !== req[k*WORD_W +: WORD_W]) begin
          $display("FAIL %s word%0d actual=%0h required=%0h", name, k,
                   act[k*WORD_W +: WORD_W], req[k*WORD_W +: WORD_W]);
          break;
        end
      end
    end
  endtask

  function automatic logic [BLOCK_W-1:0] with_nonce(input logic [BLOCK_W-1:0] b, input logic [63:0] n);
    logic [BLOCK_W-1:0] r;
    r = b;
    r[63:0] = n;
    return r;
  endfunction

  task automatic push_words(input logic [BLOCK_W-1:0] b, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.word = WORD_IDX_W'(k);
      e.blk  = b;
      e.last = (k == WORDS - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (word_valid_o) valid_cycles++;
      if (last_o) last_cycles++;
      if (word_valid_o && word_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected actual_word=%0d required=none", word_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_word", 64'(word_o), 64'(mon_e.word));
          chk("beat_last", 64'(last_o), 64'(mon_e.last));
          chk_blk("beat_reg", input_register_o, mon_e.blk);
          $display("beat word=%0d last=%0b nonce=%0h count=%0d", word_o, last_o,
                   input_register_o[63:0], block_count_o);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  task automatic load(input logic [BLOCK_W-1:0] b, input bit keep_valid, input logic [BLOCK_W-1:0] after);
    int n = 0;
    while (!load_ready_o && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("load_ready_wait", 64'(load_ready_o), 64'd1);
    valid_cycles = 0;
    last_cycles  = 0;
    load_valid_i = 1'b1;
    load_data_i  = b;
    @(posedge clk_i);
    #1;
    load_valid_i = keep_valid;
    load_data_i  = after;
    chk("first_word_valid", 64'(word_valid_o), 64'd1);
    chk("first_word_idx", 64'(word_o), 64'd0);
  endtask

  // Drives ready/auto/stop each cycle until the sequencer goes idle (or reset is forced).
  task automatic run(input int stall_n, input int auto_off_cnt, input int stop_cnt, input int rst_word);
    int stalled = 0;
    int cyc = 0;
    while (busy_o && cyc < 300) begin
      if (rst_word >= 0 && int'(word_o) == rst_word) begin
        rst_n_i = 1'b0;
        break;
      end
      if (word_o == 4'd5 && stalled < stall_n) begin
        word_ready_i = 1'b0;
        stalled++;
      end else begin
        word_ready_i = 1'b1;
      end
      auto_inc_i = (int'(block_count_o) < auto_off_cnt);
      stop_i     = (int'(block_count_o) == stop_cnt) && (word_o == 4'd7);
      if (word_o == 4'd15) load_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      cyc++;
    end
    if (cyc >= 300) begin
      checks++;
      failures++;
      $display("FAIL run_timeout actual=busy required=idle");
    end
    word_ready_i = 1'b1;
    auto_inc_i   = 1'b0;
    stop_i       = 1'b0;
    load_valid_i = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < WORDS; k++) begin
      blk_a[k*WORD_W +: WORD_W] = 64'(k);
      blk_b[k*WORD_W +: WORD_W] = 64'hA5A5_0000_0000_0000 | 64'(k);
      blk_c[k*WORD_W +: WORD_W] = 64'h3C3C_0000_0000_0000 | 64'(k * 3);
      blk_d[k*WORD_W +: WORD_W] = 64'hDEAD_BEEF_0000_0000 | 64'(k);
    end
    blk_b = with_nonce(blk_b, 64'hFFFF_FFFF_FFFF_FFFE);
    blk_c = with_nonce(blk_c, 64'h0000_0000_0000_0010);

    do_reset();
    chk("rst_valid", 64'(word_valid_o), 64'd0);
    chk("rst_word", 64'(word_o), 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("rst_count", 64'(block_count_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_load_ready", 64'(load_ready_o), 64'd1);
    chk_blk("rst_reg", input_register_o, '0);

    // Plain block, no stalls.
    push_words(blk_a, WORDS);
    load(blk_a, 1'b0, '0);
    run(0, 0, -1, -1);
    chk("t1_count", 64'(block_count_o), 64'd1);
    chk("t1_valid_cycles", 64'(valid_cycles), 64'd16);
    chk("t1_last_cycles", 64'(last_cycles), 64'd1);
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_load_ready", 64'(load_ready_o), 64'd1);

    // Three-cycle stall at word 5.
    do_reset();
    push_words(blk_a, WORDS);
    load(blk_a, 1'b0, '0);
    run(3, 0, -1, -1);
    chk("t2_count", 64'(block_count_o), 64'd1);
    chk("t2_valid_cycles", 64'(valid_cycles), 64'd19);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    chk_blk("t2_reg", input_register_o, blk_a);

    // Auto-increment across nonce wrap, three back-to-back blocks.
    do_reset();
    push_words(blk_b, WORDS);
    push_words(with_nonce(blk_b, 64'hFFFF_FFFF_FFFF_FFFF), WORDS);
    push_words(with_nonce(blk_b, 64'h0), WORDS);
    load(blk_b, 1'b0, '0);
    run(0, 2, -1, -1);
    chk("t3_count", 64'(block_count_o), 64'd3);
    chk("t3_valid_cycles", 64'(valid_cycles), 64'd48);
    chk("t3_last_cycles", 64'(last_cycles), 64'd3);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    chk_blk("t3_reg", input_register_o, with_nonce(blk_b, 64'h0));

    // Auto mode with stop at word 7 of block 2.
    do_reset();
    push_words(blk_c, WORDS);
    push_words(with_nonce(blk_c, 64'h11), WORDS);
    load(blk_c, 1'b0, '0);
    run(0, 99, 1, -1);
    chk("t4_count", 64'(block_count_o), 64'd2);
    chk("t4_load_ready", 64'(load_ready_o), 64'd1);
    chk("t4_valid_cycles", 64'(valid_cycles), 64'd32);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    chk_blk("t4_reg", input_register_o, with_nonce(blk_c, 64'h11));

    // load_valid held high with other data while streaming.
    do_reset();
    push_words(blk_a, WORDS);
    load(blk_a, 1'b1, blk_d);
    run(0, 0, -1, -1);
    chk("t5_count", 64'(block_count_o), 64'd1);
    chk("t5_valid_cycles", 64'(valid_cycles), 64'd16);
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    chk_blk("t5_reg", input_register_o, blk_a);

    // Reset asserted while word 9 is presented.
    do_reset();
    push_words(blk_a, 9);
    load(blk_a, 1'b0, '0);
    run(0, 0, -1, 9);
    #1;
    chk("t6_rst_valid", 64'(word_valid_o), 64'd0);
    chk("t6_rst_word", 64'(word_o), 64'd0);
    chk("t6_rst_count", 64'(block_count_o), 64'd0);
    chk("t6_rst_busy", 64'(busy_o), 64'd0);
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    push_words(blk_a, WORDS);
    load(blk_a, 1'b0, '0);
    run(0, 0, -1, -1);
    chk("t6_count", 64'(block_count_o), 64'd1);
    chk("t6_valid_cycles", 64'(valid_cycles), 64'd16);
    chk("t6_final_queue_empty", 64'(exp_q.size()), 64'd0);

    repeat (2) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
